// File: rtl/round_robin_arbiter8_if.sv
// Request/grant bundle between eight requesters and the round-robin arbiter.
// grant_count exists only when ARBITER_STATS_EN is defined.
interface round_robin_arbiter8_if;
    logic [7:0]  req;
    logic        bus_ready;
    logic [7:0]  gnt;
    logic [2:0]  sel;
    logic        bus_valid;
    logic        timeout;
`ifdef ARBITER_STATS_EN
    logic [31:0] grant_count;
`endif

    // Arbiter side: owns the grant and the transaction presented to the resource.
    modport master (
        input  req,
        input  bus_ready,
        output gnt,
        output sel,
        output bus_valid,
`ifdef ARBITER_STATS_EN
        output grant_count,
`endif
        output timeout
    );

    // Requester/resource side.
    modport slave (
        output req,
        output bus_ready,
        input  gnt,
        input  sel,
        input  bus_valid,
`ifdef ARBITER_STATS_EN
        input  grant_count,
`endif
        input  timeout
    );
endinterface

// File: rtl/round_robin_arbiter8.sv
// Eight-way round-robin arbiter with locked grant, valid/ready handshake and a watchdog.
// Define ARBITER_STATS_EN to add the saturating completed-transaction counter grant_count.
module round_robin_arbiter8 #(
    parameter int unsigned TIMEOUT = 16
) (
    input logic                    clock,
    input logic                    reset,
    round_robin_arbiter8_if.master bus
);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    localparam int unsigned    CntW   = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] CntMax = {CntW{1'b1}};

    state_e          state_q, state_d;
    logic [2:0]      ptr_q, ptr_d;
    logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
    logic [7:0]      gnt_q, gnt_d;
    logic [2:0]      sel_q, sel_d;
    logic            bus_valid_q, bus_valid_d;
    logic            timeout_q, timeout_d;
`ifdef ARBITER_STATS_EN
    logic [31:0]     grant_count_q, grant_count_d;
`endif

    logic            win_found;
    logic [2:0]      win_idx;
    logic [2:0]      scan_idx;
    logic            expire;

    // Search ptr, ptr+1, ... with natural 3-bit wrap; first set request wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = ptr_q;
        scan_idx  = '0;
        for (int i = 0; i < 8; i++) begin
            scan_idx = ptr_q + 3'(i);
            if (!win_found && bus.req[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
        end
    end

    assign expire = (TIMEOUT != 0) && (wait_cnt_q == CntW'(TIMEOUT - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= StIdle;
            ptr_q         <= '0;
            wait_cnt_q    <= '0;
            gnt_q         <= '0;
            sel_q         <= '0;
            bus_valid_q   <= 1'b0;
            timeout_q     <= 1'b0;
`ifdef ARBITER_STATS_EN
            grant_count_q <= '0;
`endif
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            wait_cnt_q    <= wait_cnt_d;
            gnt_q         <= gnt_d;
            sel_q         <= sel_d;
            bus_valid_q   <= bus_valid_d;
            timeout_q     <= timeout_d;
`ifdef ARBITER_STATS_EN
            grant_count_q <= grant_count_d;
`endif
        end
    end

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        wait_cnt_d    = wait_cnt_q;
        gnt_d         = gnt_q;
        sel_d         = sel_q;
        bus_valid_d   = bus_valid_q;
        timeout_d     = 1'b0;
`ifdef ARBITER_STATS_EN
        grant_count_d = grant_count_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (win_found) begin
                    state_d     = StGrant;
                    gnt_d       = 8'd1 << win_idx;
                    sel_d       = win_idx;
                    bus_valid_d = 1'b1;
                    wait_cnt_d  = '0;
                end
            end
            StGrant: begin
                // Completion takes priority over a simultaneous watchdog expiry.
                if (bus.bus_ready || expire) begin
                    state_d     = StIdle;
                    gnt_d       = '0;
                    bus_valid_d = 1'b0;
                    ptr_d       = sel_q + 3'd1;
                    timeout_d   = !bus.bus_ready;
`ifdef ARBITER_STATS_EN
                    if (bus.bus_ready && (grant_count_q != 32'hFFFF_FFFF)) begin
                        grant_count_d = grant_count_q + 32'd1;
                    end
`endif
                end else if (wait_cnt_q != CntMax) begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.gnt         = gnt_q;
        bus.sel         = sel_q;
        bus.bus_valid   = bus_valid_q;
        bus.timeout     = timeout_q;
`ifdef ARBITER_STATS_EN
        bus.grant_count = grant_count_q;
`endif
    end

    a_grant_consistent : assert property (@(posedge clock) disable iff (reset)
        (bus_valid_q == (gnt_q != 8'd0)) && (bus_valid_q == (state_q == StGrant))
        && $onehot0(gnt_q));

endmodule
